systolic_feed_ctrl: RTL and testbench
=====================================

# systolic_feed_ctrl

Sequencer between `array_mem` and the 4x4 systolic PE grid. On `start`, it performs the following steps:
- Reads matrix A and matrix B (N×N elements each) from `array_mem` through the two read ports.
- Buffers both matrices internally.
- Drives the skewed row and column wavefronts into the array edges.
- Waits for the array to drain, then pulses `done`.

It owns `en_A`, `en_B`, `read_addr_A` and `read_addr_B`, and is the only master of `array_mem`.

## Interface
Parameters:
- `N`, 4 — array dimension; matrices are N×N.
- `DW`, 16 — element width; matches `read_data_A` / `read_data_B`.
- `AW`, 7 — `array_mem` address width.
- `DRAIN_CYCLES`, 6 — cycles waited after the last feed beat before `done`.

Ports:
- `clk` in 1 — single clock; all logic is on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle request; sampled only in IDLE.
- `base_A` in AW — address of A[0][0]; latched at start.
- `base_B` in AW — address of B[0][0]; latched at start.
- `en_A`, `en_B` out 1 — read enables to `array_mem`.
- `read_addr_A`, `read_addr_B` out AW — read addresses to `array_mem`.
- `read_data_A`, `read_data_B` in DW — `array_mem` data, valid 1 cycle after address/enable.
- `a_edge` out N*DW — row-edge inputs; lane i occupies bits [i*DW +: DW].
- `b_edge` out N*DW — column-edge inputs; lane j occupies bits [j*DW +: DW].
- `feed_valid` out 1 — high while `a_edge` / `b_edge` carry a wavefront beat.
- `busy` out 1 — high from the cycle after start acceptance through the DONE cycle.
- `done` out 1 — one-cycle completion pulse.

## Operation
- Memory layout is row-major for both matrices:
  - A[i][k] at base_A + i*N + k.
  - B[k][j] at base_B + k*N + j.
  - Address arithmetic is modulo 2^AW (wraps 127→0).
- States: IDLE → LOAD → LWAIT → FEED → DRAIN → DONE → IDLE.
- IDLE:
  - All outputs are at reset values.
  - `start`=1 latches the bases and moves to LOAD; the load counter k is cleared.
- LOAD, N*N cycles, k = 0..N*N-1:
  - `en_A`=`en_B`=1.
  - `read_addr_A` = base_A+k, `read_addr_B` = base_B+k.
  - `read_data` returning in the following cycle is written to buffer slot k-1, using a registered copy of k.
- LWAIT, 1 cycle:
  - Enables are 0.
  - The last data (slot N*N-1) is captured.
- FEED, 2N-1 cycles, t = 0..2N-2:
  - `feed_valid`=1.
  - Lane i of `a_edge` = A[i][t-i] when 0 ≤ t-i < N, else 0.
  - Lane j of `b_edge` = B[t-j][j] when 0 ≤ t-j < N, else 0.
- DRAIN, DRAIN_CYCLES cycles:
  - `feed_valid`=0; edges are 0.
- DONE, 1 cycle:
  - `done`=1, `busy`=1; next state is IDLE.
- `start` outside IDLE is ignored; no queueing.
- `rst_n` low in any state:
  - Immediately forces IDLE and all outputs to reset values.
  - Buffer contents need not be cleared.
  - The operation is abandoned; no `done`.
- Reset values: `en_A`=`en_B`=0, `read_addr_A`=`read_addr_B`=0, `a_edge`=`b_edge`=0, `feed_valid`=0, `busy`=0, `done`=0.
- All outputs are registered. Data is passed through unmodified (no arithmetic on elements).

## Timing
- Edge E0 samples `start`=1 in IDLE.
- Cycles 1..16 (N=4): LOAD, with addresses base+0..base+15 on the ports.
- Cycle 17: LWAIT, with buffer slot 15 written at its end.
- Cycles 18..24: FEED (7 beats); `feed_valid` high.
- Cycles 25..30: DRAIN.
- Cycle 31: `done`=1. Cycle 32: IDLE, and a new `start` can be accepted there.
- Start-to-done latency is N*N + 1 + (2N-1) + DRAIN_CYCLES + 1 = 31 cycles at defaults.
- Back-to-back: `start` held high continuously gives one accepted run per 32 cycles.

## Test plan
- Single run:
  - Setup: A[i][k]=16*i+k at base_A=0; B[k][j]=0x100+16*k+j at base_B=32; pulse `start`.
  - Addresses: 0..15 on A and 32..47 on B in cycles 1..16.
  - FEED beat t=0: `a_edge` lane0=0x0000, others 0; `b_edge` lane0=0x0100.
  - Beat t=3: `a_edge` lanes = {A03, A12, A21, A30} = {3, 0x12, 0x21, 0x30}.
  - Beat t=6: only lane3 nonzero: A33=0x33, B33=0x133.
  - `done` at cycle 31.
- Wrap-around:
  - Setup: base_A=120.
  - `read_addr_A` sequence is 120..127, 0..7.
  - Data is fetched from the wrapped locations in the correct slots.
- Ignored start:
  - Stimulus: pulse `start` at cycles 5, 20 and 28.
  - No restart; the base latched at E0 is kept; exactly one `done` at cycle 31.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 asynchronously during FEED beat t=2.
  - `feed_valid`, `busy`, `en_A`/`en_B` and the edges go to 0 immediately; no `done`.
  - After release, a new `start` completes normally with correct data.
- Back-to-back:
  - Stimulus: `start` tied high.
  - `done` pulses at cycles 31 and 63.
  - `busy` drops for exactly 1 cycle between runs.
- Reset values:
  - Stimulus: check all outputs during and immediately after `rst_n`=0.
  - Every output is 0.

Source files
------------

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: loads A/B from array_mem, then feeds skewed wavefronts into the PE grid edges.
module systolic_feed_ctrl #(
  parameter int N = 4,
  parameter int DW = 16,
  parameter int AW = 7,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   base_A,
  input  logic [AW-1:0]   base_B,
  output logic            en_A,
  output logic            en_B,
  output logic [AW-1:0]   read_addr_A,
  output logic [AW-1:0]   read_addr_B,
  input  logic [DW-1:0]   read_data_A,
  input  logic [DW-1:0]   read_data_B,
  output logic [N*DW-1:0] a_edge,
  output logic [N*DW-1:0] b_edge,
  output logic            feed_valid,
  output logic            busy,
  output logic            done
);
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int CW = 8;

  typedef enum logic [2:0] {IDLE, LOAD, LWAIT, FEED, DRAIN, DONE} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] lat_a, lat_b, lat_a_n, lat_b_n, addr_a_n, addr_b_n;
  logic en, en_n, fv_n, busy_n, done_n;
  logic [N*DW-1:0] a_n, b_n, a_beat, b_beat;
  logic [DW-1:0] buf_a [NN];
  logic [DW-1:0] buf_b [NN];
  logic [IW-1:0] widx;
  logic wvalid;
  int ft;

  assign en_A = en;
  assign en_B = en;

  always_comb begin
    ft = (state == LWAIT) ? 0 : int'(cnt) + 1;
    a_beat = '0;
    b_beat = '0;
    // lane l carries the element whose row+col index equals the beat number
    for (int l = 0; l < N; l++)
      for (int k = 0; k < N; k++)
        if (l + k == ft) begin
          a_beat[l*DW +: DW] = buf_a[l*N+k];
          b_beat[l*DW +: DW] = buf_b[k*N+l];
        end
    state_n = state;
    cnt_n = cnt;
    lat_a_n = lat_a;
    lat_b_n = lat_b;
    en_n = 1'b0;
    addr_a_n = '0;
    addr_b_n = '0;
    fv_n = 1'b0;
    a_n = '0;
    b_n = '0;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        cnt_n = '0;
        lat_a_n = base_A;
        lat_b_n = base_B;
        en_n = 1'b1;
        addr_a_n = base_A;
        addr_b_n = base_B;
        busy_n = 1'b1;
      end
      LOAD: if (cnt == CW'(NN-1)) begin
        state_n = LWAIT;
        cnt_n = '0;
      end else begin
        cnt_n = cnt + CW'(1);
        en_n = 1'b1;
        addr_a_n = lat_a + AW'(cnt + CW'(1));
        addr_b_n = lat_b + AW'(cnt + CW'(1));
      end
      LWAIT: begin
        state_n = FEED;
        cnt_n = '0;
        fv_n = 1'b1;
        a_n = a_beat;
        b_n = b_beat;
      end
      FEED: if (cnt == CW'(2*N-2)) begin
        state_n = DRAIN;
        cnt_n = '0;
      end else begin
        cnt_n = cnt + CW'(1);
        fv_n = 1'b1;
        a_n = a_beat;
        b_n = b_beat;
      end
      DRAIN: if (cnt == CW'(DRAIN_CYCLES-1)) begin
        state_n = DONE;
        cnt_n = '0;
        done_n = 1'b1;
      end else begin
        cnt_n = cnt + CW'(1);
      end
      DONE: begin
        state_n = IDLE;
        busy_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      lat_a <= '0;
      lat_b <= '0;
      en <= 1'b0;
      read_addr_A <= '0;
      read_addr_B <= '0;
      feed_valid <= 1'b0;
      a_edge <= '0;
      b_edge <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      wvalid <= 1'b0;
      widx <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lat_a <= lat_a_n;
      lat_b <= lat_b_n;
      en <= en_n;
      read_addr_A <= addr_a_n;
      read_addr_B <= addr_b_n;
      feed_valid <= fv_n;
      a_edge <= a_n;
      b_edge <= b_n;
      busy <= busy_n;
      done <= done_n;
      wvalid <= (state == LOAD);
      widx <= cnt[IW-1:0];
    end
  end

  // read data lags the address by one cycle, so it lands in the slot of the previous count
  always_ff @(posedge clk) begin
    if (wvalid) begin
      buf_a[widx] <= read_data_A;
      buf_b[widx] <= read_data_B;
    end
  end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: directed checks of load addressing, skewed feed, timing and reset behaviour.
module tb_systolic_feed_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [6:0] base_A = '0;
  logic [6:0] base_B = '0;
  logic en_A, en_B, feed_valid, busy, done;
  logic [6:0] read_addr_A, read_addr_B;
  logic [15:0] read_data_A = '0;
  logic [15:0] read_data_B = '0;
  logic [63:0] a_edge, b_edge;
  logic [15:0] mem [128];
  logic [63:0] cap_a [7];
  logic [63:0] cap_b [7];
  int total = 0;
  int bad = 0;

  systolic_feed_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_A(base_A), .base_B(base_B),
    .en_A(en_A), .en_B(en_B), .read_addr_A(read_addr_A), .read_addr_B(read_addr_B),
    .read_data_A(read_data_A), .read_data_B(read_data_B), .a_edge(a_edge), .b_edge(b_edge),
    .feed_valid(feed_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en_A) read_data_A <= mem[read_addr_A];
    if (en_B) read_data_B <= mem[read_addr_B];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en"}, {en_A, en_B}, 0);
    check({tag, "_addr"}, {read_addr_A, read_addr_B}, 0);
    check({tag, "_a_edge"}, a_edge, 0);
    check({tag, "_b_edge"}, b_edge, 0);
    check({tag, "_flags"}, {feed_valid, busy, done}, 0);
  endtask

  function automatic logic [63:0] model_edge(input bit is_b, input logic [6:0] base, input int t);
    logic [63:0] r = '0;
    for (int l = 0; l < 4; l++) begin
      int k = t - l;
      if (k >= 0 && k < 4)
        r[l*16 +: 16] = is_b ? mem[7'(base + k*4 + l)] : mem[7'(base + l*4 + k)];
    end
    return r;
  endfunction

  task automatic init_mem();
    for (int a = 0; a < 128; a++) mem[a] = 16'hEEEE;
    for (int x = 0; x < 16; x++) begin
      mem[x] = 16'(16*(x/4) + x%4);
      mem[32+x] = 16'(16'h100 + 16*(x/4) + x%4);
    end
  endtask

  // enters in an IDLE cycle, leaves in the IDLE cycle after DONE (cycle 32)
  task automatic run(input logic [6:0] ba, input logic [6:0] bb, input bit hold, input bit ign);
    int dones = 0;
    int gaps = 0;
    base_A = ba;
    base_B = bb;
    start = 1'b1;
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
    start = hold;
    base_A = ~ba;
    base_B = ~bb;
    for (int c = 1; c <= 31; c++) begin
      if (c <= 16) begin
        check("addr_a", read_addr_A, 7'(ba + c - 1));
        check("addr_b", read_addr_B, 7'(bb + c - 1));
        check("load_en", {en_A, en_B}, 2'b11);
      end
      if (c == 17) check("lwait_en", {en_A, en_B}, 0);
      if (c >= 18 && c <= 24) begin
        cap_a[c-18] = a_edge;
        cap_b[c-18] = b_edge;
        check("feed_valid", feed_valid, 1);
        check("a_edge", a_edge, model_edge(0, ba, c - 18));
        check("b_edge", b_edge, model_edge(1, bb, c - 18));
      end
      if (c >= 25 && c <= 30) begin
        check("drain_fv", feed_valid, 0);
        check("drain_edges", a_edge | b_edge, 0);
      end
      if (c == 31) check("done_at_31", done, 1);
      if (done) dones++;
      if (!busy) gaps++;
      if (!hold) start = ign && (c == 5 || c == 20 || c == 28);
      @(posedge clk); #1;
    end
    check("done_count", dones, 1);
    check("busy_gap", gaps, 0);
    check("end_busy", busy, 0);
    check("end_done", done, 0);
  endtask

  initial begin
    int stray;
    repeat (2) @(posedge clk);
    #1 check_zero("rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("post_rst");

    init_mem();
    run(7'd0, 7'd32, 1'b0, 1'b0);
    check("t0_a", cap_a[0], 64'h0);
    check("t0_b", cap_b[0], 64'h0000_0000_0000_0100);
    check("t1_a", cap_a[1], 64'h0000_0000_0010_0001);
    check("t1_b", cap_b[1], 64'h0000_0000_0101_0110);
    check("t3_a", cap_a[3], 64'h0030_0021_0012_0003);
    check("t3_b", cap_b[3], 64'h0103_0112_0121_0130);
    check("t6_a", cap_a[6], 64'h0033_0000_0000_0000);
    check("t6_b", cap_b[6], 64'h0133_0000_0000_0000);

    for (int x = 0; x < 16; x++) mem[7'(120 + x)] = 16'(16'h200 + x);
    run(7'd120, 7'd32, 1'b0, 1'b0);
    check("wrap_t0_a", cap_a[0], 64'h0000_0000_0000_0200);
    check("wrap_t3_a", cap_a[3], 64'h020C_0209_0206_0203);
    check("wrap_t6_a", cap_a[6], 64'h020F_0000_0000_0000);

    init_mem();
    run(7'd0, 7'd32, 1'b0, 1'b1);
    check("ign_t3_a", cap_a[3], 64'h0030_0021_0012_0003);

    base_A = 7'd0;
    base_B = 7'd32;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 check("mid_fv", feed_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    check("no_done_after_rst", stray, 0);
    run(7'd0, 7'd32, 1'b0, 1'b0);
    check("rerun_t6_b", cap_b[6], 64'h0133_0000_0000_0000);

    run(7'd0, 7'd32, 1'b1, 1'b0);
    run(7'd0, 7'd32, 1'b1, 1'b0);
    start = 1'b0;

    rst_n = 1'b0;
    #1 check_zero("final_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
